// File: rtl/fifo_serializer.sv
// fifo_serializer: pops wide FIFO words and streams them out as narrow valid/ready chunks
module fifo_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int SER_WIDTH = 8,
    parameter int MSB_FIRST = 0,
    localparam int RATIO = DATA_WIDTH / SER_WIDTH,
    localparam int IDX_WIDTH = $clog2(RATIO)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_dat_i,
    output logic                  fifo_pop_o,
    output logic                  ser_valid_o,
    input  logic                  ser_ready_i,
    output logic [SER_WIDTH-1:0]  ser_dat_o,
    output logic                  ser_last_o,
    output logic                  busy_o
);
    if (RATIO < 2 || DATA_WIDTH % SER_WIDTH != 0) begin : g_bad_cfg
        $error("fifo_serializer: DATA_WIDTH must be a multiple of SER_WIDTH with ratio >= 2");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t                             state_q;
    logic [RATIO-1:0][SER_WIDTH-1:0]    hold_q;
    logic [IDX_WIDTH-1:0]               idx_q;
    logic [IDX_WIDTH-1:0]               sel;
    logic                               valid_q;
    logic                               hs;
    logic                               last;
    logic                               ld;

    assign valid_q     = (state_q == SEND);
    assign hs          = valid_q & ser_ready_i;
    assign last        = (idx_q == IDX_WIDTH'(RATIO - 1));
    assign ld          = ~fifo_empty_i & ~flush_i & (~valid_q | (hs & last));
    assign fifo_pop_o  = ld & rst_n_i;
    assign sel         = (MSB_FIRST != 0) ? IDX_WIDTH'(RATIO - 1) - idx_q : idx_q;
    assign ser_dat_o   = hold_q[sel];
    assign ser_valid_o = valid_q;
    assign ser_last_o  = valid_q & last;
    assign busy_o      = valid_q;

    // the next word loads on the last-chunk handshake, so words stream without bubbles
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            hold_q  <= '0;
        end else if (ld) begin
            state_q <= SEND;
            idx_q   <= '0;
            hold_q  <= fifo_dat_i;
        end else if (hs) begin
            if (last) begin
                state_q <= IDLE;
                idx_q   <= '0;
            end else begin
                idx_q   <= idx_q + IDX_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: directed checks of chunk order, streaming, backpressure, flush and reset
module tb_fifo_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ready = 1'b0;
    logic        empty1 = 1'b1;
    logic [31:0] dat1 = '0;
    logic        pop1, v1, l1, b1;
    logic [7:0]  sd1;
    logic        empty2 = 1'b1;
    logic [15:0] dat2 = '0;
    logic        pop2, v2, l2, b2;
    logic [3:0]  sd2;

    logic [31:0] q1[$];
    logic [15:0] q2[$];
    logic        pp1 = 1'b0, pp2 = 1'b0, pf = 1'b0;
    int          tests = 0, fails = 0, hs_cnt = 0, pop_cnt = 0;

    logic [7:0] e1 [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    logic [7:0] e5 [4] = '{8'h88, 8'h77, 8'h66, 8'h55};
    logic [7:0] d3 [6] = '{8'hD4, 8'hC3, 8'hC3, 8'hC3, 8'hB2, 8'hA1};
    logic       r3 [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    fifo_serializer u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .fifo_empty_i(empty1), .fifo_dat_i(dat1), .fifo_pop_o(pop1),
        .ser_valid_o(v1), .ser_ready_i(ready), .ser_dat_o(sd1),
        .ser_last_o(l1), .busy_o(b1)
    );

    fifo_serializer #(.DATA_WIDTH(16), .SER_WIDTH(4), .MSB_FIRST(1)) u_msb (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .fifo_empty_i(empty2), .fifo_dat_i(dat2), .fifo_pop_o(pop2),
        .ser_valid_o(v2), .ser_ready_i(ready), .ser_dat_o(sd2),
        .ser_last_o(l2), .busy_o(b2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // one cycle: apply FIFO effects of the previous edge, drive inputs, settle for sampling
    task automatic cyc(input logic rn, input logic rdy, input logic fl);
        @(negedge clk);
        if (pf) begin
            q1.delete();
            q2.delete();
        end else begin
            if (pp1) void'(q1.pop_front());
            if (pp2) void'(q2.pop_front());
        end
        rst_n  = rn;
        ready  = rdy;
        flush  = fl;
        empty1 = (q1.size() == 0);
        dat1   = empty1 ? 32'h0 : q1[0];
        empty2 = (q2.size() == 0);
        dat2   = empty2 ? 16'h0 : q2[0];
        #1;
        pp1 = pop1;
        pp2 = pop2;
        pf  = fl;
        if (v1 && rdy) hs_cnt++;
        if (pop1) pop_cnt++;
    endtask

    task automatic exp1(input string tag, input logic v, input logic [7:0] d, input logic l, input logic p);
        chk({tag, ".valid"}, v1, v);
        chk({tag, ".busy"}, b1, v);
        if (v) chk({tag, ".dat"}, sd1, d);
        chk({tag, ".last"}, l1, l);
        chk({tag, ".pop"}, pop1, p);
    endtask

    initial begin
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        exp1("reset", 0, 8'h00, 0, 0);
        chk("reset.dat", sd1, 0);
        chk("reset.msb_valid", v2, 0);

        q1.push_back(32'hA1B2C3D4);
        cyc(1, 1, 0);
        exp1("t1.pop", 0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0);
            exp1("t1.chunk", 1, e1[i], i == 3, 0);
        end
        cyc(1, 1, 0);
        exp1("t1.end", 0, 8'h00, 0, 0);

        q1.push_back(32'h03020100);
        q1.push_back(32'h07060504);
        cyc(1, 1, 0);
        exp1("t2.pop", 0, 8'h00, 0, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 1, 0);
            exp1("t2.chunk", 1, 8'(i), i == 3 || i == 7, i == 3);
        end
        cyc(1, 1, 0);
        exp1("t2.end", 0, 8'h00, 0, 0);
        chk("t2.fifo_empty", empty1, 1);

        hs_cnt  = 0;
        pop_cnt = 0;
        q1.push_back(32'hA1B2C3D4);
        cyc(1, 1, 0);
        exp1("t3.pop", 0, 8'h00, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(1, r3[i], 0);
            exp1("t3.chunk", 1, d3[i], i == 5, 0);
        end
        cyc(1, 1, 0);
        exp1("t3.end", 0, 8'h00, 0, 0);
        chk("t3.handshakes", hs_cnt, 4);
        chk("t3.pops", pop_cnt, 1);

        q1.push_back(32'hA1B2C3D4);
        q1.push_back(32'h11223344);
        cyc(1, 1, 0);
        exp1("t4.pop", 0, 8'h00, 0, 1);
        cyc(1, 1, 0);
        exp1("t4.c0", 1, 8'hD4, 0, 0);
        cyc(1, 1, 0);
        exp1("t4.c1", 1, 8'hC3, 0, 0);
        cyc(1, 1, 1);
        exp1("t4.flush", 1, 8'hB2, 0, 0);
        cyc(1, 1, 0);
        exp1("t4.post", 0, 8'h00, 0, 0);
        cyc(1, 1, 0);
        exp1("t4.quiet", 0, 8'h00, 0, 0);

        q1.push_back(32'hA1B2C3D4);
        q1.push_back(32'h55667788);
        cyc(1, 1, 0);
        exp1("t5.pop", 0, 8'h00, 0, 1);
        cyc(1, 1, 0);
        exp1("t5.c0", 1, 8'hD4, 0, 0);
        cyc(0, 1, 0);
        exp1("t5.rst0", 1, 8'hC3, 0, 0);
        cyc(0, 1, 0);
        exp1("t5.rst1", 0, 8'h00, 0, 0);
        chk("t5.rst1.dat", sd1, 0);
        cyc(1, 1, 0);
        exp1("t5.pop2", 0, 8'h00, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0);
            exp1("t5.chunk", 1, e5[i], i == 3, 0);
        end
        cyc(1, 1, 0);
        exp1("t5.end", 0, 8'h00, 0, 0);

        q2.push_back(16'h1234);
        cyc(1, 1, 0);
        chk("t6.pop", pop2, 1);
        chk("t6.idle", v2, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1, 1, 0);
            chk("t6.valid", v2, 1);
            chk("t6.dat", sd2, i);
            chk("t6.last", l2, i == 4);
            chk("t6.nopop", pop2, 0);
        end
        cyc(1, 1, 0);
        chk("t6.end", v2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fifo_serializer.md
# fifo_serializer

Downstream stage of the common `fifo`. It pops `DATA_WIDTH`-bit words from the FIFO read port and emits each word as `DATA_WIDTH/SER_WIDTH` narrow chunks on a valid/ready stream. Typical use is driving a narrow peripheral datapath, such as an SPI or UART shift engine or a byte bus, from a wide buffered queue. The block sustains one chunk per cycle with no bubbles between words.

## Interface
Parameters:
- `DATA_WIDTH`, 32: FIFO word width. Must be an integer multiple of `SER_WIDTH`.
- `SER_WIDTH`, 8: output chunk width.
- `MSB_FIRST`, 0: chunk order. 0 emits bits [SER_WIDTH-1:0] first; 1 emits the top chunk first.
- `RATIO`, DATA_WIDTH/SER_WIDTH: derived, not overridden. Must be ≥ 2; elaboration error otherwise.
- `IDX_WIDTH`, $clog2(RATIO): derived.

Ports:
- `clk_i` in 1: clock. All state changes on the rising edge.
- `rst_n_i` in 1: reset. Synchronous, active-low.
- `flush_i` in 1: synchronous abort of the word in progress. Normally tied to the FIFO `flush_i`.
- `fifo_empty_i` in 1: FIFO `empty_o`.
- `fifo_dat_i` in DATA_WIDTH: FIFO `dat_o`. Valid combinationally while `fifo_empty_i`=0.
- `fifo_pop_o` out 1: FIFO `pop_i`.
- `ser_valid_o` out 1: chunk valid.
- `ser_ready_i` in 1: downstream ready.
- `ser_dat_o` out SER_WIDTH: current chunk.
- `ser_last_o` out 1: current chunk is the final chunk of its word.
- `busy_o` out 1: a word is held. Equals `ser_valid_o`.

## Operation
- State:
  - `hold_q` [DATA_WIDTH]: the held word.
  - `idx_q` [IDX_WIDTH]: index of the current chunk.
  - `valid_q`: a word is held.
- Two-state FSM, encoded by `valid_q`:
  - IDLE (`valid_q`=0): no word held.
  - SEND (`valid_q`=1): emitting chunks.
- Handshake `hs` = `valid_q` & `ser_ready_i`.
- `last` = (`idx_q` == RATIO-1).
- Load condition `ld` = ~`fifo_empty_i` & ~`flush_i` & (~`valid_q` | (`hs` & `last`)).
- `fifo_pop_o` = `ld` & `rst_n_i`. This is combinational and is the only pop source. A pop is never issued while the FIFO is empty, during flush, or while reset is asserted.
- Next state, in priority order:
  - `rst_n_i`=0 or `flush_i`=1: `valid_q`←0, `idx_q`←0. `hold_q` is don't-care; it is cleared on reset.
  - `ld`: `hold_q`←`fifo_dat_i`, `idx_q`←0, `valid_q`←1. Transition IDLE→SEND, or SEND→SEND back-to-back.
  - `hs` & `last` & ~`ld`: `valid_q`←0, `idx_q`←0. Transition SEND→IDLE.
  - `hs` & ~`last`: `idx_q`←`idx_q`+1.
  - Otherwise: hold.
- Chunk selection:
  - `ser_dat_o` = `hold_q` chunk `idx_q` when `MSB_FIRST`=0.
  - `ser_dat_o` = `hold_q` chunk RATIO-1-`idx_q` when `MSB_FIRST`=1.
  - `ser_dat_o` is driven from registers only.
- `ser_last_o` = `valid_q` & `last`.
- Stream rules:
  - While `ser_valid_o`=1 and `ser_ready_i`=0, `ser_dat_o` and `ser_last_o` are stable.
  - `ser_valid_o` never drops without a handshake, except on flush or reset.
  - `ser_valid_o` does not depend combinationally on `ser_ready_i`.
- Flush takes priority over a same-cycle handshake. The in-flight word is discarded with no further chunks, and nothing is popped that cycle.

## Timing
- Reset values: `ser_valid_o`=0, `ser_last_o`=0, `busy_o`=0, `ser_dat_o`=0, `fifo_pop_o`=0.
- Latency: FIFO becomes non-empty in cycle t with the block idle → pop in t → chunk 0 valid in t+1.
- Throughput: with `ser_ready_i`=1 and the FIFO non-empty, one chunk per cycle. A word takes exactly RATIO cycles, and the next word's pop coincides with the last-chunk handshake, giving zero idle cycles.
- FIFO empty at the last-chunk handshake: `ser_valid_o` falls in the next cycle, and the block re-enters IDLE.
- `idx_q` never exceeds RATIO-1 and never wraps via overflow; it resets explicitly on load or completion.
- Reset or flush asserted mid-word: outputs are at reset values in the cycle after the edge. The remaining chunks are lost.

## Test plan
Configuration unless noted: DATA_WIDTH=32, SER_WIDTH=8, MSB_FIRST=0.

1. Single word: push 0xA1B2C3D4, `ser_ready_i`=1 → one pop pulse. Chunks D4, C3, B2, A1 appear on 4 consecutive cycles starting one cycle after the pop. `ser_last_o`=1 only with A1. `ser_valid_o` is 0 afterward.
2. Back-to-back: push 0x03020100 and 0x07060504, ready=1 → 8 consecutive valid cycles carrying 00 through 07. The second pop fires in the same cycle as the 03/last handshake. The FIFO ends empty.
3. Backpressure: one word, ready pattern 1,0,0,1,1,1 → chunk C3 is held stable for 3 cycles. Exactly 4 handshakes occur, and no extra pop is issued.
4. Flush mid-word: flush during chunk B2 with a second word queued → valid=0 next cycle. No pop occurs on the flush cycle. The FIFO is flushed too, and no further chunks appear.
5. Reset mid-word: assert `rst_n_i`=0 for 2 cycles during chunk C3 → all outputs at reset values. `fifo_pop_o`=0 throughout. After release, a new word serializes from chunk 0.
6. MSB_FIRST=1, DATA_WIDTH=16, SER_WIDTH=4: word 0x1234 → chunks 1, 2, 3, 4, with last on 4.
